coax_tx_predistorter: RTL

Parametrised transmit pre-distortion stage between the coax bit encoder and the line driver pins. It registers the encoded serial bit and its complement, and produces a delayed copy of the bit for pre-emphasis. The delay is selectable at run time rather than fixed at a quarter bit. When the frame ends, an optional damping tail holds the driver active for a programmable number of clocks before releasing the line.

---
 rtl/coax_tx_pkg.sv | 20 ++
 rtl/coax_tx_tap_delay.sv | 41 ++++
 rtl/coax_tx_predistorter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/coax_tx_pkg.sv
// Shared definitions for the coax transmit blocks: state encoding and
// delay clamp / counter width helpers.
package coax_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    TAIL   = 2'd2
  } state_e;

  function automatic int clamp_max(input int val, input int max_val);
    return (val > max_val) ? max_val : val;
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int width_of(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/coax_tx_tap_delay.sv
// Variable-tap delay line for the pre-emphasis leg. Prime forces the line to
// ones; when prime and shift coincide the new bit enters a freshly primed line.
module coax_tx_tap_delay #(
  parameter int DEPTH = 4,
  parameter int SW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          prime_i,
  input  logic          shift_i,
  input  logic          din_i,
  input  logic [SW-1:0] sel_i,
  output logic          tap_o
);

  logic [DEPTH-1:0] line_q, line_d, base;

  always_comb begin
    base   = prime_i ? '1 : line_q;
    line_d = line_q;
    if (shift_i) begin
      line_d = {base[DEPTH-2:0], din_i};
    end else if (prime_i) begin
      line_d = '1;
    end
  end

  // sel_i = 0 selects no tap, so the leg reads 0.
  always_comb begin
    tap_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_i == SW'(i + 1)) tap_o = base[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) line_q <= '1;
    else          line_q <= line_d;
  end

endmodule

// File: rtl/coax_tx_predistorter.sv
// Coax transmit pre-distortion stage: registered bit, complement and delayed
// pre-emphasis leg, plus an optional damping tail (COAX_TX_PREDISTORTER_TAIL_EN).
//
//   state  | meaning
//   IDLE   | line released, delay line primed, delay tracks delay_sel
//   ACTIVE | frame in progress, delay frozen
//   TAIL   | frame over, driver held active for TAIL_CLOCKS
module coax_tx_predistorter
  import coax_tx_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int MAX_DELAY      = CLOCKS_PER_BIT / 2,
  parameter int DEFAULT_DELAY  = CLOCKS_PER_BIT / 4,
  parameter int TAIL_CLOCKS    = CLOCKS_PER_BIT / 2,
  localparam int DW            = width_of(MAX_DELAY)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          active_input,
  input  logic          tx_input,
  input  logic [DW-1:0] delay_sel,
  output logic          active_output,
  output logic          tx_output,
  output logic          tx_delay,
  output logic          tx_n,
  output logic          busy
);

  if (CLOCKS_PER_BIT < 4) begin : g_chk_cpb
    $error("CLOCKS_PER_BIT must be at least 4");
  end
  if (MAX_DELAY < 2) begin : g_chk_max
    $error("MAX_DELAY must be at least 2");
  end
  if (DEFAULT_DELAY < 1 || DEFAULT_DELAY > MAX_DELAY) begin : g_chk_def
    $error("DEFAULT_DELAY must be within 1..MAX_DELAY");
  end
  if (TAIL_CLOCKS < 0) begin : g_chk_tail
    $error("TAIL_CLOCKS must not be negative");
  end

  state_e        state_q, state_d;
  logic [DW-1:0] lat_q, lat_d, lat_eff, sel_clamped;
  logic          prime, shift, tap;
  logic          act_d, tx_d, txn_d, dly_d, busy_d;

`ifdef COAX_TX_PREDISTORTER_TAIL_EN
  localparam int CW = width_of(TAIL_CLOCKS);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign sel_clamped = DW'(clamp_max(int'(delay_sel), MAX_DELAY));

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    lat_eff = lat_q;
    prime   = (state_q != ACTIVE);
    shift   = 1'b0;
    act_d   = 1'b0;
    tx_d    = 1'b0;
    txn_d   = 1'b0;
    dly_d   = 1'b0;
`ifdef COAX_TX_PREDISTORTER_TAIL_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        // The frame's first edge already uses the delay sampled with it.
        lat_d   = sel_clamped;
        lat_eff = sel_clamped;
        if (active_input) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!active_input) begin
`ifdef COAX_TX_PREDISTORTER_TAIL_EN
          if (TAIL_CLOCKS > 0) begin
            state_d = TAIL;
            cnt_d   = CW'(TAIL_CLOCKS - 1);
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef COAX_TX_PREDISTORTER_TAIL_EN
      TAIL: begin
        if (active_input)     state_d = ACTIVE;
        else if (cnt_q == '0) state_d = IDLE;
        else                  cnt_d   = cnt_q - 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered on this edge.
    if (state_d == ACTIVE) begin
      shift = 1'b1;
      act_d = 1'b1;
      tx_d  = tx_input;
      txn_d = ~tx_input;
      dly_d = tap;
    end else if (state_d == TAIL) begin
      act_d = 1'b1;
      dly_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  coax_tx_tap_delay #(
    .DEPTH (MAX_DELAY),
    .SW    (DW)
  ) u_tap (
    .clk_i   (clk),
    .rst_n_i (reset_n),
    .prime_i (prime),
    .shift_i (shift),
    .din_i   (tx_input),
    .sel_i   (lat_eff),
    .tap_o   (tap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      lat_q         <= DW'(DEFAULT_DELAY);
      active_output <= 1'b0;
      tx_output     <= 1'b0;
      tx_delay      <= 1'b0;
      tx_n          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      active_output <= act_d;
      tx_output     <= tx_d;
      tx_delay      <= dly_d;
      tx_n          <= txn_d;
      busy          <= busy_d;
    end
  end

`ifdef COAX_TX_PREDISTORTER_TAIL_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

endmodule
